// File: rtl/hsem_mc.sv
// hsem_mc: AHB-Lite hardware semaphore block. It supports 2-step (write) and 1-step (read-lock)
// locking, owner-checked release, keyed bulk clear, and a per-core interrupt raised on each release.

module hsem_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       rlr,
  input  logic       bulk,
  input  logic       wlock,
  input  logic [3:0] wcid,
  input  logic [7:0] wpid,
  input  logic [3:0] master,
  output logic       lock,
  output logic [3:0] coreid,
  output logic [7:0] pid,
  output logic       rel
);
  // A release must name the exact owner; a bulk clear only has to match the core.
  assign rel = lock & ((wr & ~wlock & (coreid == wcid) & (pid == wpid)) |
                       (bulk & (coreid == wcid)));

  always_ff @(posedge clk) begin
    if (rst) begin
      lock   <= 1'b0;
      coreid <= '0;
      pid    <= '0;
    end else if (rel) begin
      lock   <= 1'b0;
      coreid <= '0;
      pid    <= '0;
    end else if (!lock && wr && wlock) begin
      lock   <= 1'b1;
      coreid <= wcid;
      pid    <= wpid;
    end else if (!lock && rlr) begin
      lock   <= 1'b1;
      coreid <= master;
      pid    <= '0;
    end
  end
endmodule

module hsem_mc #(
  parameter int          NUM_SEM  = 32,
  parameter int          NUM_CORE = 4,
  parameter logic [15:0] CLR_KEY  = 16'hA5A5
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                hsel,
  input  logic                hready,
  input  logic [1:0]          htrans,
  input  logic                hwrite,
  input  logic [2:0]          hsize,
  input  logic [11:0]         haddr,
  input  logic [31:0]         hwdata,
  input  logic [3:0]          hmaster,
  output logic                hreadyout,
  output logic                hresp,
  output logic [31:0]         hrdata,
  output logic [NUM_CORE-1:0] intr
);
  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [11:0] addr;
    logic [3:0]  master;
  } req_t;

  req_t dp;

  assign hreadyout = 1'b1;
  assign hresp     = 1'b0;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dp <= '0;
    end else if (hready) begin
      dp.vld    <= hsel & htrans[1];
      dp.wr     <= hwrite;
      dp.addr   <= haddr;
      dp.master <= hmaster;
    end
  end

  logic [4:0] sidx;
  logic [3:0] cidx;
  logic [1:0] creg;
  logic       is_r, is_rlr, is_core, is_cr, bulk;

  assign sidx    = dp.addr[6:2];
  assign cidx    = dp.addr[7:4];
  assign creg    = dp.addr[3:2];
  assign is_r    = dp.vld & (dp.addr[11:7] == 5'd0);
  assign is_rlr  = dp.vld & (dp.addr[11:7] == 5'd1);
  assign is_core = dp.vld & (dp.addr[11:8] == 4'd1);
  assign is_cr   = dp.vld & (dp.addr[11:2] == 10'h080);
  assign bulk    = is_cr & dp.wr & (hwdata[31:16] == CLR_KEY);

  logic [NUM_SEM-1:0]      wr_r, rd_rlr, lock, rel;
  logic [NUM_SEM-1:0][3:0] coreid;
  logic [NUM_SEM-1:0][7:0] pid;

  always_comb begin
    wr_r   = '0;
    rd_rlr = '0;
    for (int i = 0; i < NUM_SEM; i++) begin
      wr_r[i]   = is_r & dp.wr & (sidx == 5'(i));
      rd_rlr[i] = is_rlr & ~dp.wr & (sidx == 5'(i));
    end
  end

  hsem_lane u_lane [NUM_SEM-1:0] (
    .clk    (hclk),
    .rst    (hreset),
    .wr     (wr_r),
    .rlr    (rd_rlr),
    .bulk   (bulk),
    .wlock  (hwdata[31]),
    .wcid   (hwdata[11:8]),
    .wpid   (hwdata[7:0]),
    .master (dp.master),
    .lock   (lock),
    .coreid (coreid),
    .pid    (pid),
    .rel    (rel)
  );

  logic [NUM_CORE-1:0][NUM_SEM-1:0] ier, isr, isr_set, icr_clr, misr;
  logic [NUM_CORE-1:0]              ier_wr;

  always_comb begin
    isr_set = '0;
    icr_clr = '0;
    ier_wr  = '0;
    misr    = '0;
    for (int c = 0; c < NUM_CORE; c++) begin
      for (int i = 0; i < NUM_SEM; i++)
        isr_set[c][i] = rel[i] & (coreid[i] != 4'(c));
      ier_wr[c] = is_core & dp.wr & (cidx == 4'(c)) & (creg == 2'd0);
      if (is_core && dp.wr && cidx == 4'(c) && creg == 2'd1)
        icr_clr[c] = hwdata[NUM_SEM-1:0];
      misr[c] = isr[c] & ier[c];
    end
  end

  // Set wins over a same-cycle ICR clear; intr follows MISR one cycle later.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      ier  <= '0;
      isr  <= '0;
      intr <= '0;
    end else begin
      for (int c = 0; c < NUM_CORE; c++) begin
        if (ier_wr[c]) ier[c] <= hwdata[NUM_SEM-1:0];
        isr[c]  <= (isr[c] & ~icr_clr[c]) | isr_set[c];
        intr[c] <= |misr[c];
      end
    end
  end

  // An RLR read of a free semaphore returns the state it is about to take.
  always_comb begin
    hrdata = '0;
    if (dp.vld && !dp.wr) begin
      for (int i = 0; i < NUM_SEM; i++) begin
        if ((is_r || is_rlr) && sidx == 5'(i)) begin
          if (is_rlr && !lock[i]) hrdata = {1'b1, 19'b0, dp.master, 8'h00};
          else                    hrdata = {lock[i], 19'b0, coreid[i], pid[i]};
        end
      end
      for (int c = 0; c < NUM_CORE; c++) begin
        if (is_core && cidx == 4'(c)) begin
          case (creg)
            2'd0:    hrdata = 32'(ier[c]);
            2'd2:    hrdata = 32'(isr[c]);
            2'd3:    hrdata = 32'(misr[c]);
            default: hrdata = '0;
          endcase
        end
      end
    end
  end

  logic unused;
  assign unused = ^{hsize, htrans[0], dp.addr[1:0], hwdata[30:12]};
endmodule

// File: tb/tb_hsem_mc.sv
// tb_hsem_mc: table-driven directed vectors, multi-cycle corner sequences and a randomized run
// checked against a behavioural semaphore model.

module tb_hsem_mc;
  localparam int NS = 32;
  localparam int NC = 4;

  logic          hclk = 1'b0;
  logic          hreset, hsel, hready, hwrite;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [11:0]   haddr;
  logic [31:0]   hwdata;
  logic [3:0]    hmaster;
  logic          hreadyout, hresp;
  logic [31:0]   hrdata;
  logic [NC-1:0] intr;

  always #5 hclk = ~hclk;

  hsem_mc #(.NUM_SEM(NS), .NUM_CORE(NC), .CLR_KEY(16'hA5A5)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready(hready), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hmaster(hmaster),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .intr(intr)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Behavioural model: per-semaphore owner records and per-core interrupt words
  bit          m_lk[NS];
  logic [3:0]  m_cid[NS];
  logic [7:0]  m_pid[NS];
  logic [31:0] m_ier[NC];
  logic [31:0] m_isr[NC];

  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin m_lk[i] = 0; m_cid[i] = 0; m_pid[i] = 0; end
    for (int c = 0; c < NC; c++) begin m_ier[c] = 0; m_isr[c] = 0; end
  endfunction

  function automatic void m_release(int i);
    for (int c = 0; c < NC; c++)
      if (c != int'(m_cid[i])) m_isr[c][i] = 1'b1;
    m_lk[i] = 0; m_cid[i] = 0; m_pid[i] = 0;
  endfunction

  function automatic logic [31:0] m_rd(int i);
    return {m_lk[i], 19'b0, m_cid[i], m_pid[i]};
  endfunction

  function automatic logic [NC-1:0] m_intr();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = |(m_isr[c] & m_ier[c]);
    return v;
  endfunction

  function automatic logic [31:0] m_xfer(bit w, logic [11:0] a, logic [3:0] m, logic [31:0] d);
    int i;
    int c;
    logic [31:0] r;
    i = int'(a[6:2]);
    c = int'(a[7:4]);
    r = 0;
    if (a < 12'h080) begin
      if (w) begin
        if (d[31] && !m_lk[i]) begin m_lk[i] = 1; m_cid[i] = d[11:8]; m_pid[i] = d[7:0]; end
        else if (!d[31] && m_lk[i] && m_cid[i] == d[11:8] && m_pid[i] == d[7:0]) m_release(i);
      end else r = m_rd(i);
    end else if (a < 12'h100) begin
      if (!w) begin
        if (!m_lk[i]) begin m_lk[i] = 1; m_cid[i] = m; m_pid[i] = 0; end
        r = m_rd(i);
      end
    end else if (a < 12'h200) begin
      if (c < NC) begin
        case (a[3:2])
          2'd0: if (w) m_ier[c] = d; else r = m_ier[c];
          2'd1: if (w) m_isr[c] = m_isr[c] & ~d;
          2'd2: if (!w) r = m_isr[c];
          default: if (!w) r = m_isr[c] & m_ier[c];
        endcase
      end
    end else if (a == 12'h200 && w && d[31:16] == 16'hA5A5) begin
      for (int k = 0; k < NS; k++)
        if (m_lk[k] && m_cid[k] == d[11:8]) m_release(k);
    end
    return r;
  endfunction

  task automatic xfer(input bit w, input logic [11:0] a, input logic [3:0] m,
                      input logic [31:0] d, output logic [31:0] r);
    @(negedge hclk);
    hsel = 1; htrans = 2'b10; hwrite = w; haddr = a; hmaster = m;
    @(negedge hclk);
    hsel = 0; htrans = 2'b00; hwdata = d;
    r = hrdata;
  endtask

  task automatic run(input bit w, input logic [11:0] a, input logic [3:0] m,
                     input logic [31:0] d, output logic [31:0] r, output logic [31:0] e);
    xfer(w, a, m, d, r);
    e = m_xfer(w, a, m, d);
  endtask

  task automatic xfer2(input bit w1, input logic [11:0] a1, input logic [3:0] m1, input logic [31:0] d1,
                       input bit w2, input logic [11:0] a2, input logic [3:0] m2, input logic [31:0] d2,
                       output logic [31:0] r1, output logic [31:0] r2);
    logic [31:0] e;
    @(negedge hclk);
    hsel = 1; htrans = 2'b10; hwrite = w1; haddr = a1; hmaster = m1;
    @(negedge hclk);
    hwrite = w2; haddr = a2; hmaster = m2; hwdata = d1;
    r1 = hrdata;
    @(negedge hclk);
    hsel = 0; htrans = 2'b00; hwdata = d2;
    r2 = hrdata;
    e = m_xfer(w1, a1, m1, d1);
    e = m_xfer(w2, a2, m2, d2);
  endtask

  typedef struct {
    bit          w;
    logic [11:0] a;
    logic [3:0]  m;
    logic [31:0] d;
    bit          chk;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit w, logic [11:0] a, logic [3:0] m, logic [31:0] d,
                              bit chk, logic [31:0] exp, string nm);
    vec_t v;
    v.w = w; v.a = a; v.m = m; v.d = d; v.chk = chk; v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, r2, e, d;
    logic [11:0] a;
    logic [3:0]  m;
    int          kind, idx, c;
    bit          w;

    hreset = 1; hsel = 0; hready = 1; htrans = 0; hwrite = 0; hsize = 3'b010;
    haddr = 0; hwdata = 0; hmaster = 0;
    m_reset();
    repeat (3) @(negedge hclk);
    check("rst_hrdata", hrdata, 0);
    check("rst_intr", intr, 0);
    hreset = 0;

    add(0, 12'h00C, 1, 0, 1, 32'h0, "rst_r3");
    add(0, 12'h108, 0, 0, 1, 32'h0, "rst_isr0");
    add(0, 12'h100, 0, 0, 1, 32'h0, "rst_ier0");
    add(1, 12'h00C, 1, 32'h8000_0107, 0, 0, "lock_r3");
    add(0, 12'h00C, 1, 0, 1, 32'h8000_0107, "r3_locked");
    add(1, 12'h00C, 2, 32'h8000_0209, 0, 0, "steal_r3");
    add(0, 12'h00C, 2, 0, 1, 32'h8000_0107, "r3_kept");
    add(1, 12'h00C, 1, 32'h0000_0108, 0, 0, "bad_pid");
    add(0, 12'h00C, 0, 0, 1, 32'h8000_0107, "r3_badpid");
    add(0, 12'h108, 0, 0, 1, 32'h0, "isr0_badpid");
    add(0, 12'h128, 0, 0, 1, 32'h0, "isr2_badpid");
    add(1, 12'h100, 0, 32'h20, 0, 0, "ier0_wr");
    add(0, 12'h100, 0, 0, 1, 32'h20, "ier0_rd");
    add(0, 12'h094, 2, 0, 1, 32'h8000_0200, "rlr5_lock");
    add(0, 12'h014, 3, 0, 1, 32'h8000_0200, "r5_owner");
    add(1, 12'h014, 2, 32'h0000_0200, 0, 0, "rel5");
    add(0, 12'h014, 0, 0, 1, 32'h0, "r5_free");
    add(0, 12'h108, 0, 0, 1, 32'h20, "isr0_rel5");
    add(0, 12'h118, 0, 0, 1, 32'h20, "isr1_rel5");
    add(0, 12'h128, 0, 0, 1, 32'h0, "isr2_rel5");
    add(0, 12'h138, 0, 0, 1, 32'h20, "isr3_rel5");
    add(0, 12'h10C, 0, 0, 1, 32'h20, "misr0");
    add(0, 12'h11C, 0, 0, 1, 32'h0, "misr1");
    add(1, 12'h104, 0, 32'h20, 0, 0, "icr0");
    add(0, 12'h108, 0, 0, 1, 32'h0, "isr0_clr");
    add(0, 12'h118, 0, 0, 1, 32'h20, "isr1_keep");
    add(0, 12'h200, 0, 0, 1, 32'h0, "cr_rd");
    add(1, 12'h140, 0, 32'hFFFF_FFFF, 0, 0, "core4_wr");
    add(0, 12'h140, 0, 0, 1, 32'h0, "core4_rd");
    add(0, 12'h300, 0, 0, 1, 32'h0, "unmapped_rd");
    add(1, 12'h00C, 1, 32'h0000_0107, 0, 0, "rel3");
    add(0, 12'h00C, 0, 0, 1, 32'h0, "r3_free");

    foreach (tbl[k]) begin
      run(tbl[k].w, tbl[k].a, tbl[k].m, tbl[k].d, r, e);
      if (tbl[k].chk) check(tbl[k].nm, r, tbl[k].exp);
    end

    // Back-to-back RLR of a free semaphore by two cores
    xfer2(0, 12'h094, 2, 0, 0, 12'h094, 3, 0, r, r2);
    check("b2b_rlr_first", r, 32'h8000_0200);
    check("b2b_rlr_second", r2, 32'h8000_0200);
    run(0, 12'h014, 0, 0, r, e);
    check("b2b_rlr_state", r, 32'h8000_0200);

    // Read-after-write in back-to-back transfers
    xfer2(1, 12'h028, 3, 32'h8000_0305, 0, 12'h028, 3, 0, r, r2);
    check("raw_lock", r2, 32'h8000_0305);
    xfer2(1, 12'h028, 3, 32'h0000_0305, 0, 12'h028, 3, 0, r, r2);
    check("raw_release", r2, 32'h0);

    // Release interrupt timing on core 0
    run(1, 12'h014, 2, 32'h0000_0200, r, e);
    @(negedge hclk);
    check("intr_lag", intr, 4'b0000);
    @(negedge hclk);
    check("intr_set", intr, 4'b0001);
    run(1, 12'h104, 0, 32'h20, r, e);
    @(negedge hclk);
    check("intr_hold", intr, 4'b0001);
    @(negedge hclk);
    check("intr_clr", intr, 4'b0000);

    // Bulk clear
    for (int k = 0; k < NC; k++) run(1, 12'(12'h104 + 16 * k), 0, 32'hFFFF_FFFF, r, e);
    run(1, 12'h000, 1, 32'h8000_0100, r, e);
    run(1, 12'h010, 1, 32'h8000_0100, r, e);
    run(1, 12'h07C, 1, 32'h8000_0100, r, e);
    run(1, 12'h01C, 2, 32'h8000_0203, r, e);
    run(1, 12'h200, 0, 32'h1234_0100, r, e);
    run(0, 12'h010, 0, 0, r, e);
    check("badkey_r4", r, 32'h8000_0100);
    run(0, 12'h07C, 0, 0, r, e);
    check("badkey_r31", r, 32'h8000_0100);
    run(0, 12'h108, 0, 0, r, e);
    check("badkey_isr0", r, 32'h0);
    run(1, 12'h200, 0, 32'hA5A5_0100, r, e);
    run(0, 12'h000, 0, 0, r, e);
    check("bulk_r0", r, 32'h0);
    run(0, 12'h010, 0, 0, r, e);
    check("bulk_r4", r, 32'h0);
    run(0, 12'h07C, 0, 0, r, e);
    check("bulk_r31", r, 32'h0);
    run(0, 12'h01C, 0, 0, r, e);
    check("bulk_r7_kept", r, 32'h8000_0203);
    run(0, 12'h108, 0, 0, r, e);
    check("bulk_isr0", r, 32'h8000_0011);
    run(0, 12'h118, 0, 0, r, e);
    check("bulk_isr1", r, 32'h0);
    run(0, 12'h128, 0, 0, r, e);
    check("bulk_isr2", r, 32'h8000_0011);
    run(0, 12'h138, 0, 0, r, e);
    check("bulk_isr3", r, 32'h8000_0011);

    // Reset landing on a lock write's data phase
    run(1, 12'h120, 0, 32'hFFFF_FFFF, r, e);
    repeat (2) @(negedge hclk);
    check("intr2_pre", intr, 4'b0100);
    @(negedge hclk);
    hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 12'h030; hmaster = 1;
    @(negedge hclk);
    hsel = 0; htrans = 0; hwdata = 32'h8000_0101; hreset = 1;
    @(negedge hclk);
    hreset = 0;
    m_reset();
    check("rst_mid_hrdata", hrdata, 0);
    check("rst_mid_intr", intr, 0);
    for (int k = 0; k < NS; k++) begin
      run(0, 12'(4 * k), 0, 0, r, e);
      check($sformatf("rst_mid_r%0d", k), r, 32'h0);
    end
    run(0, 12'h120, 0, 0, r, e);
    check("rst_mid_ier2", r, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, NS - 1);
      c    = $urandom_range(0, 5);
      w    = 1'($urandom_range(0, 1));
      m    = 4'($urandom_range(0, 3));
      d    = $urandom;
      case (kind)
        0, 1, 2: begin
          a = 12'(4 * idx);
          if (m_lk[idx] && $urandom_range(0, 1) == 1) d = {1'b0, 19'b0, m_cid[idx], m_pid[idx]};
          else d = {$urandom_range(0, 1) == 1, 19'b0, 4'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
        end
        3, 4:    a = 12'(12'h080 + 4 * idx);
        5, 6, 7: a = 12'(12'h100 + 16 * c + 4 * $urandom_range(0, 3));
        8: begin
          a = 12'h200;
          d = {($urandom_range(0, 1) == 1) ? 16'hA5A5 : 16'($urandom), 4'h0,
               4'($urandom_range(0, 3)), 8'h00};
        end
        default: a = 12'(12'h204 + 4 * $urandom_range(0, 894));
      endcase
      run(w, a, m, d, r, e);
      if (!w) check($sformatf("rand_rd_%0d_a%h", n, a), r, e);
      repeat (2) @(negedge hclk);
      check($sformatf("rand_intr_%0d", n), intr, m_intr());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
